// File: rtl/rx_cmd_ctrl.sv
// Command sequencer behind the UART receiver: decodes opcode/operand frames into
// register-file writes/reads and ALU operations, and streams results toward TX.
module rx_cmd_ctrl #(
  parameter int Data_Width = 8,
  parameter int Addr_Width = 4,
  parameter int Fun_Width  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    RX_D_VLD,
  input  logic [Data_Width-1:0]   RX_P_DATA,
  input  logic                    RX_ERR,
  output logic                    RF_WrEn,
  output logic                    RF_RdEn,
  output logic [Addr_Width-1:0]   RF_Address,
  output logic [Data_Width-1:0]   RF_WrData,
  input  logic [Data_Width-1:0]   RF_RdData,
  input  logic                    RF_RdData_VLD,
  output logic                    ALU_EN,
  output logic [Fun_Width-1:0]    ALU_FUN,
  input  logic [2*Data_Width-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic                    CLK_GATE_EN,
  output logic [Data_Width-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    TX_FULL
);

  localparam logic [Data_Width-1:0] OPC_RF_WR   = Data_Width'(8'hAA);
  localparam logic [Data_Width-1:0] OPC_RF_RD   = Data_Width'(8'hBB);
  localparam logic [Data_Width-1:0] OPC_ALU_OP  = Data_Width'(8'hCC);
  localparam logic [Data_Width-1:0] OPC_ALU_NOP = Data_Width'(8'hDD);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_ADDR  = 4'd1,
    ST_WR_DATA  = 4'd2,
    ST_RD_ADDR  = 4'd3,
    ST_RD_WAIT  = 4'd4,
    ST_OP_A     = 4'd5,
    ST_OP_B     = 4'd6,
    ST_ALU_FUN  = 4'd7,
    ST_ALU_WAIT = 4'd8,
    ST_TX_RD    = 4'd9,
    ST_TX_LO    = 4'd10,
    ST_TX_HI    = 4'd11
  } state_t;

  state_t                  state_r;
  logic [Addr_Width-1:0]   addr_r;
  logic [Data_Width-1:0]   rd_data_r;
  logic [2*Data_Width-1:0] alu_res_r;

  // Command FSM; every output is a register updated here.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= ST_IDLE;
      addr_r      <= '0;
      rd_data_r   <= '0;
      alu_res_r   <= '0;
      RF_WrEn     <= 1'b0;
      RF_RdEn     <= 1'b0;
      RF_Address  <= '0;
      RF_WrData   <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
    end else begin
      RF_WrEn  <= 1'b0;
      RF_RdEn  <= 1'b0;
      ALU_EN   <= 1'b0;
      TX_D_VLD <= 1'b0;
      // A corrupted frame abandons whatever command is in flight.
      if (RX_D_VLD && RX_ERR) begin
        state_r     <= ST_IDLE;
        CLK_GATE_EN <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (RX_D_VLD) begin
              case (RX_P_DATA)
                OPC_RF_WR:   state_r <= ST_WR_ADDR;
                OPC_RF_RD:   state_r <= ST_RD_ADDR;
                OPC_ALU_OP:  state_r <= ST_OP_A;
                OPC_ALU_NOP: state_r <= ST_ALU_FUN;
                default:     state_r <= ST_IDLE;
              endcase
            end
          end
          ST_WR_ADDR: begin
            if (RX_D_VLD) begin
              addr_r  <= RX_P_DATA[Addr_Width-1:0];
              state_r <= ST_WR_DATA;
            end
          end
          ST_WR_DATA: begin
            if (RX_D_VLD) begin
              RF_WrEn    <= 1'b1;
              RF_Address <= addr_r;
              RF_WrData  <= RX_P_DATA;
              state_r    <= ST_IDLE;
            end
          end
          ST_RD_ADDR: begin
            if (RX_D_VLD) begin
              RF_RdEn    <= 1'b1;
              RF_Address <= RX_P_DATA[Addr_Width-1:0];
              state_r    <= ST_RD_WAIT;
            end
          end
          ST_RD_WAIT: begin
            if (RF_RdData_VLD) begin
              rd_data_r <= RF_RdData;
              state_r   <= ST_TX_RD;
            end
          end
          ST_OP_A: begin
            if (RX_D_VLD) begin
              RF_WrEn    <= 1'b1;
              RF_Address <= '0;
              RF_WrData  <= RX_P_DATA;
              state_r    <= ST_OP_B;
            end
          end
          ST_OP_B: begin
            if (RX_D_VLD) begin
              RF_WrEn    <= 1'b1;
              RF_Address <= Addr_Width'(1);
              RF_WrData  <= RX_P_DATA;
              state_r    <= ST_ALU_FUN;
            end
          end
          ST_ALU_FUN: begin
            if (RX_D_VLD) begin
              ALU_EN      <= 1'b1;
              ALU_FUN     <= RX_P_DATA[Fun_Width-1:0];
              CLK_GATE_EN <= 1'b1;
              state_r     <= ST_ALU_WAIT;
            end
          end
          ST_ALU_WAIT: begin
            if (ALU_OUT_VLD) begin
              alu_res_r <= ALU_OUT;
              state_r   <= ST_TX_LO;
            end
          end
          ST_TX_RD: begin
            if (!TX_FULL) begin
              TX_D_VLD  <= 1'b1;
              TX_P_DATA <= rd_data_r;
              state_r   <= ST_IDLE;
            end
          end
          ST_TX_LO: begin
            // The ALU stays clocked for exactly one cycle past its result.
            CLK_GATE_EN <= 1'b0;
            if (!TX_FULL) begin
              TX_D_VLD  <= 1'b1;
              TX_P_DATA <= alu_res_r[Data_Width-1:0];
              state_r   <= ST_TX_HI;
            end
          end
          ST_TX_HI: begin
            if (!TX_FULL) begin
              TX_D_VLD  <= 1'b1;
              TX_P_DATA <= alu_res_r[2*Data_Width-1:Data_Width];
              state_r   <= ST_IDLE;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
